// File: rtl/cam_lru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_lru_pkg
// Description : Shared types and constants for the cam_lru tag cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_lru_pkg;

    typedef enum logic [0:0] {
        CL_IDLE  = 1'b0,
        CL_FLUSH = 1'b1
    } cl_state_t;

    localparam int c_def_words     = 8;
    localparam int c_def_addr_left = $clog2(c_def_words) - 1;

    // Entry index / age counter for the default geometry.
    typedef logic [c_def_addr_left:0] cl_age_t;

    // Reset ages form the identity permutation: entry i starts with age i.
    function automatic int cl_reset_age(input int idx);
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_lru_if.sv
`default_nettype none
// ============================================================================
// Module      : cam_lru_if
// Description : Lookup / fill / invalidate / flush bus of the cam_lru cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface cam_lru_if #(
    parameter int WORDS     = 8,
    parameter int BITS      = 32,
    parameter int TAG_SZ    = 26,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
);
    logic                lookup_valid;
    logic [TAG_SZ-1:0]   lookup_tag;
    logic                rsp_valid;
    logic                rsp_hit;
    logic [BITS-1:0]     rsp_data;
    logic [ADDR_LEFT:0]  rsp_index;
    logic                fill_valid;
    logic [TAG_SZ-1:0]   fill_tag;
    logic [BITS-1:0]     fill_data;
    logic                inval_valid;
    logic [TAG_SZ-1:0]   inval_tag;
    logic                flush;
    logic                busy;
    logic                cache_full;
    logic                evict_valid;
    logic [TAG_SZ-1:0]   evict_tag;
    logic [BITS-1:0]     evict_data;

    modport master (
        output lookup_valid, lookup_tag, fill_valid, fill_tag, fill_data,
               inval_valid, inval_tag, flush,
        input  rsp_valid, rsp_hit, rsp_data, rsp_index, busy, cache_full,
               evict_valid, evict_tag, evict_data
    );

    modport slave (
        input  lookup_valid, lookup_tag, fill_valid, fill_tag, fill_data,
               inval_valid, inval_tag, flush,
        output rsp_valid, rsp_hit, rsp_data, rsp_index, busy, cache_full,
               evict_valid, evict_tag, evict_data
    );
endinterface
`default_nettype wire

// File: rtl/cam_lru_age.sv
`default_nettype none
// ============================================================================
// Module      : cam_lru_age
// Description : True-LRU age counters; applies lookup then fill touch per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lru_age
    import cam_lru_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 a_valid,
    input  logic [ADDR_LEFT:0]   a_idx,
    input  logic                 b_valid,
    input  logic [ADDR_LEFT:0]   b_idx,
    output logic [ADDR_LEFT:0]   victim
);
    typedef logic [ADDR_LEFT:0] idx_t;

    idx_t r_age   [WORDS];
    idx_t w_age_a [WORDS];
    idx_t w_age_b [WORDS];

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            w_age_a[i] = r_age[i];
            if (a_valid) begin
                if (idx_t'(i) == a_idx)
                    w_age_a[i] = '0;
                else if (r_age[i] < r_age[a_idx])
                    w_age_a[i] = r_age[i] + idx_t'(1);
            end
        end
    end

    // Victim is chosen after the lookup touch so a same-cycle hit is protected.
    always_comb begin
        victim = '0;
        for (int i = 0; i < WORDS; i++)
            if (w_age_a[i] == idx_t'(WORDS - 1))
                victim = idx_t'(i);
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            w_age_b[i] = w_age_a[i];
            if (b_valid) begin
                if (idx_t'(i) == b_idx)
                    w_age_b[i] = '0;
                else if (w_age_a[i] < w_age_a[b_idx])
                    w_age_b[i] = w_age_a[i] + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < WORDS; i++)
                r_age[i] <= idx_t'(cl_reset_age(i));
        end else begin
            for (int i = 0; i < WORDS; i++)
                r_age[i] <= w_age_b[i];
        end
    end
endmodule
`default_nettype wire

// File: rtl/cam_lru.sv
`default_nettype none
// ============================================================================
// Module      : cam_lru
// Description : Fully associative tag CAM with true-LRU eviction and flush FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lru
    import cam_lru_pkg::*;
#(
    parameter int WORDS     = 8,
    parameter int BITS      = 32,
    parameter int TAG_SZ    = 26,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
    input  logic      clk,
    input  logic      rst_,
    cam_lru_if.slave  bus
);
    typedef logic [ADDR_LEFT:0] idx_t;

    logic [WORDS-1:0]   r_valid;
    logic [TAG_SZ-1:0]  r_tag  [WORDS];
    logic [BITS-1:0]    r_data [WORDS];
    cl_state_t          r_state;
    idx_t               r_ptr;
    logic               r_busy;
    logic               r_rsp_valid, r_rsp_hit, r_evict_valid;
    logic [BITS-1:0]    r_rsp_data, r_evict_data;
    idx_t               r_rsp_index;
    logic [TAG_SZ-1:0]  r_evict_tag;

    logic               w_idle, w_lk_hit, w_inv_hit, w_fill_hit, w_free;
    idx_t               w_lk_idx, w_inv_idx, w_fill_hit_idx, w_free_idx;
    idx_t               w_fill_idx, w_victim;
    logic [WORDS-1:0]   w_valid_inv;
    logic               w_lk_act, w_inv_act, w_fill_act, w_evict;

    assign w_idle     = (r_state == CL_IDLE);
    assign w_lk_act   = bus.lookup_valid && w_idle && w_lk_hit;
    assign w_inv_act  = bus.inval_valid && w_idle && w_inv_hit;
    assign w_fill_act = bus.fill_valid && w_idle;

    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_idx  = '0;
        w_inv_hit = 1'b0;
        w_inv_idx = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_valid[i] && r_tag[i] == bus.lookup_tag) begin
                w_lk_hit = 1'b1;
                w_lk_idx = idx_t'(i);
            end
            if (r_valid[i] && r_tag[i] == bus.inval_tag) begin
                w_inv_hit = 1'b1;
                w_inv_idx = idx_t'(i);
            end
        end
    end

    // Fill sees the valid map after this cycle's invalidate has been applied.
    always_comb begin
        w_valid_inv = r_valid;
        if (w_inv_act)
            w_valid_inv[w_inv_idx] = 1'b0;
        w_fill_hit     = 1'b0;
        w_fill_hit_idx = '0;
        w_free         = 1'b0;
        w_free_idx     = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (w_valid_inv[i] && r_tag[i] == bus.fill_tag) begin
                w_fill_hit     = 1'b1;
                w_fill_hit_idx = idx_t'(i);
            end
            if (!w_valid_inv[i]) begin
                w_free     = 1'b1;
                w_free_idx = idx_t'(i);
            end
        end
    end

    always_comb begin
        w_fill_idx = w_victim;
        if (w_fill_hit)
            w_fill_idx = w_fill_hit_idx;
        else if (w_free)
            w_fill_idx = w_free_idx;
    end

    assign w_evict = w_fill_act && !w_fill_hit && !w_free;

    cam_lru_age #(
        .WORDS     (WORDS),
        .ADDR_LEFT (ADDR_LEFT)
    ) u_age (
        .clk     (clk),
        .rst_    (rst_),
        .a_valid (w_lk_act),
        .a_idx   (w_lk_idx),
        .b_valid (w_fill_act),
        .b_idx   (w_fill_idx),
        .victim  (w_victim)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_valid <= '0;
            for (int i = 0; i < WORDS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_state       <= CL_IDLE;
            r_ptr         <= '0;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_hit     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_index   <= '0;
            r_evict_valid <= 1'b0;
            r_evict_tag   <= '0;
            r_evict_data  <= '0;
        end else begin
            r_rsp_valid   <= bus.lookup_valid;
            r_rsp_hit     <= w_lk_act;
            r_rsp_data    <= w_lk_act ? r_data[w_lk_idx] : '0;
            r_rsp_index   <= w_lk_act ? w_lk_idx : '0;
            r_evict_valid <= w_evict;
            r_evict_tag   <= w_evict ? r_tag[w_victim] : '0;
            r_evict_data  <= w_evict ? r_data[w_victim] : '0;
            case (r_state)
                CL_IDLE: begin
                    if (w_inv_act) begin
                        r_valid[w_inv_idx] <= 1'b0;
                        r_tag[w_inv_idx]   <= '0;
                        r_data[w_inv_idx]  <= '0;
                    end
                    // Written after the invalidate so a same-tag fill wins.
                    if (w_fill_act) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_tag[w_fill_idx]   <= bus.fill_tag;
                        r_data[w_fill_idx]  <= bus.fill_data;
                    end
                    if (bus.flush) begin
                        r_state <= CL_FLUSH;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CL_FLUSH: begin
                    r_valid[r_ptr] <= 1'b0;
                    r_tag[r_ptr]   <= '0;
                    r_data[r_ptr]  <= '0;
                    if (r_ptr == idx_t'(WORDS - 1)) begin
                        r_state <= CL_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + idx_t'(1);
                    end
                end
                default: begin
                    r_state <= CL_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_hit     = r_rsp_hit;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_index   = r_rsp_index;
    assign bus.busy        = r_busy;
    assign bus.cache_full  = &r_valid;
    assign bus.evict_valid = r_evict_valid;
    assign bus.evict_tag   = r_evict_tag;
    assign bus.evict_data  = r_evict_data;
endmodule
`default_nettype wire

// File: tb/tb_cam_lru.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_lru
// Description : Self-checking bench for cam_lru against an LRU-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lru;
    localparam int WORDS  = 4;
    localparam int BITS   = 32;
    localparam int TAG_SZ = 26;
    localparam int AL     = $clog2(WORDS) - 1;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    cam_lru_if #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ), .ADDR_LEFT(AL)) bus ();

    cam_lru #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TAG_SZ), .ADDR_LEFT(AL)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: entry contents plus an LRU list of indices, MRU first.
    bit                m_valid [WORDS];
    logic [TAG_SZ-1:0] m_tag   [WORDS];
    logic [BITS-1:0]   m_data  [WORDS];
    int                lru[$];
    bit                m_busy;
    int                m_ptr;
    bit                e_rsp_valid, e_rsp_hit, e_ev_valid;
    logic [BITS-1:0]   e_rsp_data, e_ev_data;
    int                e_rsp_index;
    logic [TAG_SZ-1:0] e_ev_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        lru.delete();
        for (int i = 0; i < WORDS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            lru.push_back(i);
        end
        m_busy = 1'b0;
        m_ptr  = 0;
    endfunction

    function automatic int find(input logic [TAG_SZ-1:0] t);
        for (int i = 0; i < WORDS; i++)
            if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic void touch(input int e);
        for (int k = 0; k < lru.size(); k++)
            if (lru[k] == e) begin
                lru.delete(k);
                break;
            end
        lru.push_front(e);
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < WORDS; i++)
            if (!m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all();
        chk("rsp_valid", bus.rsp_valid, e_rsp_valid);
        chk("rsp_hit", bus.rsp_hit, e_rsp_hit);
        chk("rsp_data", bus.rsp_data, e_rsp_data);
        chk("rsp_index", bus.rsp_index, e_rsp_index);
        chk("evict_valid", bus.evict_valid, e_ev_valid);
        chk("evict_tag", bus.evict_tag, e_ev_tag);
        chk("evict_data", bus.evict_data, e_ev_data);
        chk("busy", bus.busy, m_busy);
        chk("cache_full", bus.cache_full, m_full());
    endtask

    task automatic cyc(input bit lv, input logic [TAG_SZ-1:0] lt,
                       input bit iv, input logic [TAG_SZ-1:0] it,
                       input bit fv, input logic [TAG_SZ-1:0] ft, input logic [BITS-1:0] fd,
                       input bit fl);
        int h;
        bus.lookup_valid = lv; bus.lookup_tag = lt;
        bus.inval_valid  = iv; bus.inval_tag  = it;
        bus.fill_valid   = fv; bus.fill_tag   = ft; bus.fill_data = fd;
        bus.flush        = fl;
        e_rsp_valid = lv; e_rsp_hit = 1'b0; e_rsp_data = '0; e_rsp_index = 0;
        e_ev_valid  = 1'b0; e_ev_tag = '0; e_ev_data = '0;
        if (m_busy) begin
            m_valid[m_ptr] = 1'b0; m_tag[m_ptr] = '0; m_data[m_ptr] = '0;
            m_ptr++;
            if (m_ptr == WORDS) m_busy = 1'b0;
        end else begin
            if (lv) begin
                h = find(lt);
                if (h >= 0) begin
                    e_rsp_hit = 1'b1; e_rsp_data = m_data[h]; e_rsp_index = h;
                    touch(h);
                end
            end
            if (iv) begin
                h = find(it);
                if (h >= 0) begin
                    m_valid[h] = 1'b0; m_tag[h] = '0; m_data[h] = '0;
                end
            end
            if (fv) begin
                h = find(ft);
                if (h < 0)
                    for (int i = WORDS - 1; i >= 0; i--)
                        if (!m_valid[i]) h = i;
                if (h < 0) begin
                    h = lru[$];
                    e_ev_valid = 1'b1; e_ev_tag = m_tag[h]; e_ev_data = m_data[h];
                end
                m_valid[h] = 1'b1; m_tag[h] = ft; m_data[h] = fd;
                touch(h);
            end
            if (fl) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic look(input logic [TAG_SZ-1:0] t);
        cyc(1, t, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input logic [TAG_SZ-1:0] t, input logic [BITS-1:0] d);
        cyc(0, 0, 0, 0, 1, t, d, 0);
    endtask

    initial begin
        bus.lookup_valid = 0; bus.lookup_tag = '0;
        bus.inval_valid  = 0; bus.inval_tag  = '0;
        bus.fill_valid   = 0; bus.fill_tag   = '0; bus.fill_data = '0;
        bus.flush        = 0;
        model_reset();
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_cache_full", bus.cache_full, 0);
        chk("reset_evict_valid", bus.evict_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        look(26'h5);
        chk("miss_after_reset", bus.rsp_hit, 0);
        for (int i = 1; i <= 4; i++) fill(TAG_SZ'(i), BITS'(32'hA0 + i));
        chk("full_after_fills", bus.cache_full, 1);
        look(26'h3);
        chk("hit3_data", bus.rsp_data, 32'hA3);
        chk("hit3_index", bus.rsp_index, 2);

        look(26'h1);
        fill(26'h9, 32'hB9);
        chk("evict_tag_lru", bus.evict_tag, 26'h2);
        chk("evict_data_lru", bus.evict_data, 32'hA2);
        look(26'h9);
        chk("hit9_index", bus.rsp_index, 1);

        fill(26'h4, 32'hFF);
        look(26'h4);
        chk("update4_data", bus.rsp_data, 32'hFF);

        cyc(0, 0, 1, 26'h3, 1, 26'h3, 32'h77, 0);
        look(26'h3);
        chk("inval_fill_same", bus.rsp_data, 32'h77);
        cyc(0, 0, 1, 26'h3, 0, 0, 0, 0);
        look(26'h3);
        chk("inval_miss", bus.rsp_hit, 0);
        fill(26'h3, 32'h33);

        // Flush from full; lookups keep issuing while busy.
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < WORDS; i++) look(26'h4);
        chk("flush_done_busy", bus.busy, 0);
        for (int t = 1; t <= 9; t++) look(TAG_SZ'(t));

        // Reset in the middle of a flush.
        for (int i = 1; i <= 3; i++) fill(TAG_SZ'(i + 16), BITS'(i));
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        look(26'h11);
        #2;
        rst_ = 1'b0;
        #1;
        model_reset();
        chk("midflush_busy", bus.busy, 0);
        chk("midflush_full", bus.cache_full, 0);
        chk("midflush_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 1; i <= 3; i++) look(TAG_SZ'(i + 16));

        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 1) == 1, TAG_SZ'($urandom_range(1, 6)),
                $urandom_range(0, 3) == 0, TAG_SZ'($urandom_range(1, 6)),
                $urandom_range(0, 1) == 1, TAG_SZ'($urandom_range(1, 6)), BITS'($urandom()),
                $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cam_lru.md
Name: cam_lru

Overview:
- Fully associative tag CAM cache with true-LRU replacement, registered lookup responses, tag-based invalidate, and a multi-cycle flush sequencer.
- Sits between the pipeline fetch/memory stage and backing memory.
- Successor to the first-generation CAM cache: a fill never stalls on full; it evicts the LRU entry and reports the victim for write-back.

Parameters:
WORDS, 8, number of entries (power of 2, >=2)
BITS, 32, data bits per entry
TAG_SZ, 26, tag bits
ADDR_LEFT, $clog2(WORDS)-1, MSB of entry index / age counter

Ports:
clk  in  1  system clock
rst_  in  1  reset, asynchronous, active-low
lookup_valid  in  1  lookup request this cycle
lookup_tag  in  TAG_SZ  tag to search
rsp_valid  out  1  lookup response valid (one cycle after request)
rsp_hit  out  1  lookup hit
rsp_data  out  BITS  hit data, 0 on miss
rsp_index  out  ADDR_LEFT+1  matching entry, 0 on miss
fill_valid  in  1  install/update entry
fill_tag  in  TAG_SZ  tag to install
fill_data  in  BITS  data to install
inval_valid  in  1  invalidate by tag
inval_tag  in  TAG_SZ  tag to invalidate
flush  in  1  start full-cache flush (pulse)
busy  out  1  flush in progress
cache_full  out  1  all entries valid (combinational from state)
evict_valid  out  1  registered pulse: fill displaced a valid entry
evict_tag  out  TAG_SZ  displaced tag
evict_data  out  BITS  displaced data

Behaviour:
- One clock domain. Async active-low reset.
- Reset state: all valid bits 0, data/tags 0, age[i]=i, FSM IDLE. All outputs 0 (cache_full=0).
- Ages: per-entry ADDR_LEFT+1-bit counters that always form a permutation of 0..WORDS-1. 0 = MRU, WORDS-1 = LRU.
- Touch(e): age[e]<=0; every entry with age < old age[e] increments; all others hold.
- Lookup, 1-cycle latency:
  - The search uses pre-edge state.
  - On the next cycle rsp_valid=1 with hit/data/index registered.
  - A hit touches the entry.
  - Back-to-back lookups are supported every cycle.
- Fill:
  - Tag already valid: overwrite data in place and touch. No eviction, no duplicate entry.
  - Else, if an invalid entry exists: install at the lowest-index invalid entry and touch.
  - Else (full): victim = the entry with age==WORDS-1. Install there and touch. Next cycle evict_valid=1 with the victim's old tag/data.
- Invalidate:
  - A matching valid entry has its valid bit cleared and its data/tag zeroed.
  - Age is unchanged; the permutation is preserved.
  - A miss has no effect.
- Same-cycle ordering, applied in this order:
  1. lookup search and touch
  2. invalidate
  3. fill (fill ends MRU)
- Fill and inval on the same tag: the entry ends valid with fill_data.
- A lookup in the same cycle as a fill of the same tag responds from pre-fill state.
- FSM: IDLE, FLUSH.
  - IDLE -> FLUSH on flush=1: ptr<=0, busy=1.
  - FLUSH: one entry cleared per cycle (valid, tag, data <= 0). Ages are untouched.
  - After clearing entry WORDS-1: -> IDLE, busy=0. busy is high for exactly WORDS cycles.
  - During FLUSH: lookups still produce rsp_valid with rsp_hit=0; fill and inval are ignored; flush is ignored.
- Reset mid-flush: immediate return to IDLE with all entries invalid.
- cache_full=&valid. It reflects registered state and drops the cycle after any inval or flush clears an entry.
- Tag compare is full TAG_SZ. At most one entry ever matches; the design guarantees this.

Decomposition:
- Package cam_lru_pkg: FSM state enum (CL_IDLE, CL_FLUSH), an age-index typedef parameterised by ADDR_LEFT, and the reset age constants.
- Sub-module cam_lru_age: holds the age counters. Takes two touch requests (lookup, fill) per cycle applied in order, and outputs the victim index (age==WORDS-1).
- Top level: CAM arrays, match/free-slot search, response/evict registers, flush FSM.

Test Plan (WORDS=4):
- Reset then lookup tag 0x5 -> next cycle rsp_valid=1, rsp_hit=0, rsp_data=0. After reset busy=0, cache_full=0, evict_valid=0.
- Fill tags 0x1..0x4 with data 0xA1..0xA4 -> entries 0..3 filled, cache_full=1, no evict. Lookup 0x3 -> hit, rsp_data=0xA3, rsp_index=2.
- From full, lookup 0x1 (touch), then fill 0x9/0xB9 -> victim is 0x2 (LRU). evict_valid=1, evict_tag=0x2, evict_data=0xA2. Lookup 0x9 -> hit, index 1.
- Fill existing tag 0x4 with 0xFF -> no evict. Lookup 0x4 returns 0xFF; cache_full stays 1.
- Same-cycle inval 0x3 and fill 0x3/0x77 -> lookup 0x3 hits 0x77. Inval 0x3 alone -> next lookup misses, cache_full=0.
- flush pulse -> busy high exactly 4 cycles; lookups during flush miss. Afterwards every tag misses. Assert rst_ mid-flush -> busy=0 immediately, all entries invalid.
